// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared state encodings and defaults for input conditioning
package sw_debounce_pkg;

    // Debounce FSM states; WAIT states are the qualification windows
    typedef enum logic [1:0] {
        ST_LOW_STABLE  = 2'd0,
        ST_WAIT_HIGH   = 2'd1,
        ST_HIGH_STABLE = 2'd2,
        ST_WAIT_LOW    = 2'd3
    } db_state_t;

    // 1 ms of stability at a 100 MHz clock
    localparam int DEBOUNCE_CNT = 100_000;

    // Default synchronizer depth for asynchronous board inputs
    localparam int SYNC_DEPTH = 2;

    // True while a candidate transition is being qualified
    function automatic logic is_wait(input db_state_t s);
        return (s == ST_WAIT_HIGH) || (s == ST_WAIT_LOW);
    endfunction

endpackage

// File: rtl/sw_debounce_sync_ff.sv
// rtl/sw_debounce_sync_ff.sv - multi-flop synchronizer for asynchronous board inputs
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the asynchronous input through the flop chain; stage 0 may go metastable
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch debouncer with clean level and rise/fall pulses
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int CNT_MAX     = DEBOUNCE_CNT,
    parameter int SYNC_STAGES = SYNC_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall,
    output logic busy
);

    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          sw_sync;
    db_state_t     state;
    db_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          rise_d;
    logic          fall_d;
    logic          rise_q;
    logic          fall_q;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sw_raw),
        .q    (sw_sync)
    );

    // State, stability counter and edge-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_LOW_STABLE;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Next state: any opposite sample in a WAIT state falls back to the stable state it came from
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_LOW_STABLE: begin
                if (sw_sync) begin
                    state_next = ST_WAIT_HIGH;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sw_sync) begin
                    state_next = ST_LOW_STABLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_HIGH_STABLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_HIGH_STABLE: begin
                if (!sw_sync) begin
                    state_next = ST_WAIT_LOW;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (sw_sync) begin
                    state_next = ST_HIGH_STABLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_LOW_STABLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = ST_LOW_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs: level and busy decode the state register, pulses mark qualified WAIT exits
    always_comb begin
        rise_d   = (state == ST_WAIT_HIGH) && (state_next == ST_HIGH_STABLE);
        fall_d   = (state == ST_WAIT_LOW)  && (state_next == ST_LOW_STABLE);
        sw_level = (state == ST_HIGH_STABLE) || (state == ST_WAIT_LOW);
        busy     = is_wait(state);
        sw_rise  = rise_q;
        sw_fall  = fall_q;
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce with CNT_MAX=4, SYNC_STAGES=2
module tb_sw_debounce;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw_raw = 1'b0;
    logic sw_level;
    logic sw_rise;
    logic sw_fall;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Expected {sw_level, sw_rise, sw_fall, busy} after a given clock edge
    typedef struct {
        int         at_cyc;
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    logic prev_pulse = 1'b0;

    sw_debounce #(
        .CNT_MAX    (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .sw_level(sw_level),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic step(input string tag, input logic rst, input logic raw, input logic [3:0] exp);
        exp_t e;
        reset  = rst;
        sw_raw = raw;
        e.at_cyc = cyc + 1;
        e.tag    = tag;
        e.exp    = exp;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input string tag, input logic raw, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, raw, exp);
    endtask

    // Compare DUT outputs against queued expectations, away from the active edge
    always @(negedge clk) begin
        logic pulse;
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at_cyc < cyc) check({e.tag, "_missed"}, 4'b1111, 4'b0000);
            else check(e.tag, {sw_level, sw_rise, sw_fall, busy}, e.exp);
        end
        if (cyc >= 1) begin
            pulse = sw_rise | sw_fall;
            check("rise_fall_excl", {3'b000, sw_rise & sw_fall}, 4'b0000);
            check("pulse_not_back_to_back", {3'b000, pulse & prev_pulse}, 4'b0000);
            prev_pulse = pulse;
        end
    end

    // Encoded expectations: {level, rise, fall, busy}
    initial begin
        @(negedge clk);

        // Reset held 3 cycles with raw high
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, 4'b0000);

        // Raw still high at release: qualifies normally, busy from E+2, rise after E+6
        hold("press_sync", 1'b1, 4'b0000, 2);
        hold("press_wait", 1'b1, 4'b0001, 4);
        hold("press_rise", 1'b1, 4'b1100, 1);
        hold("press_high", 1'b1, 4'b1000, 3);

        // Clean release
        hold("rel_sync", 1'b0, 4'b1000, 2);
        hold("rel_wait", 1'b0, 4'b1001, 4);
        hold("rel_fall", 1'b0, 4'b0010, 1);
        hold("rel_low",  1'b0, 4'b0000, 3);

        // Bounce 1,0,1,0,1 then low: WAIT entered and abandoned, never a rise
        step("bounce", 1'b0, 1'b1, 4'b0000);
        step("bounce", 1'b0, 1'b0, 4'b0000);
        step("bounce", 1'b0, 1'b1, 4'b0001);
        step("bounce", 1'b0, 1'b0, 4'b0000);
        step("bounce", 1'b0, 1'b1, 4'b0001);
        step("bounce", 1'b0, 1'b0, 4'b0000);
        step("bounce", 1'b0, 1'b0, 4'b0001);
        hold("bounce_low", 1'b0, 4'b0000, 4);

        // Restart: high 3, low 1, high held -> rise 6 edges after the final rising sample
        step("restart", 1'b0, 1'b1, 4'b0000);
        step("restart", 1'b0, 1'b1, 4'b0000);
        step("restart", 1'b0, 1'b1, 4'b0001);
        step("restart", 1'b0, 1'b0, 4'b0001);
        step("restart", 1'b0, 1'b1, 4'b0001);
        step("restart_drop", 1'b0, 1'b1, 4'b0000);
        hold("restart_wait", 1'b1, 4'b0001, 4);
        hold("restart_rise", 1'b1, 4'b1100, 1);
        hold("restart_high", 1'b1, 4'b1000, 2);

        // Back to low for the reset-mid-qualification case
        hold("rel2_sync", 1'b0, 4'b1000, 2);
        hold("rel2_wait", 1'b0, 4'b1001, 4);
        hold("rel2_fall", 1'b0, 4'b0010, 1);
        hold("rel2_low",  1'b0, 4'b0000, 2);

        // Reset while busy in WAIT_HIGH, then a full requalification
        hold("midrst_pre",  1'b1, 4'b0000, 2);
        hold("midrst_wait", 1'b1, 4'b0001, 2);
        step("midrst_reset", 1'b1, 1'b1, 4'b0000);
        hold("midrst_sync", 1'b1, 4'b0000, 2);
        hold("midrst_requal", 1'b1, 4'b0001, 4);
        hold("midrst_rise", 1'b1, 4'b1100, 1);
        hold("midrst_high", 1'b1, 4'b1000, 2);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) check("scoreboard_drained", 4'(sb.size()), 4'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
